// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: synchronized, debounced switches, LED/debug LED outputs,
// sticky switch rising-edge flags with a maskable level interrupt.
module mmio_gpio #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
  parameter int unsigned NUM_SW          = 4,
  parameter int unsigned NUM_LED         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        bus_addr,
  input  logic [31:0]        bus_wdata,
  input  logic               bus_we,
  input  logic               bus_re,
  output logic [31:0]        bus_rdata,
  output logic               bus_hit,
  input  logic [NUM_SW-1:0]  switches,
  output logic [NUM_LED-1:0] leds,
  output logic               debug_led,
  output logic               irq
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] OFF_SW_IN   = 2'd0;
  localparam logic [1:0] OFF_LED_OUT = 2'd1;
  localparam logic [1:0] OFF_SW_EDGE = 2'd2;
  localparam logic [1:0] OFF_IRQ_EN  = 2'd3;

  logic [NUM_SW-1:0] meta;
  logic [NUM_SW-1:0] sync;
  logic [NUM_SW-1:0] stable;
  logic [NUM_SW-1:0] stable_nxt;
  logic [NUM_SW-1:0] sw_edge;
  logic [NUM_SW-1:0] sw_edge_nxt;
  logic [NUM_SW-1:0] irq_en;
  logic [NUM_SW-1:0] irq_en_nxt;
  logic [NUM_SW-1:0] clr;
  logic              sel;
  logic              wr;
  logic [1:0]        offset;
  logic              unused_ok;

  assign sel       = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign offset    = bus_addr[3:2];
  assign wr        = sel & bus_we;
  assign bus_hit   = sel & (bus_we | bus_re);
  assign unused_ok = ^{bus_addr[1:0], bus_wdata};

  // Zero-wait-state read mux; returns pre-write values on a same-cycle store
  always_comb begin
    bus_rdata = '0;
    if (sel && bus_re) begin
      case (offset)
        OFF_SW_IN:   bus_rdata[NUM_SW-1:0] = stable;
        OFF_LED_OUT: begin
          bus_rdata[NUM_LED-1:0] = leds;
          bus_rdata[8]           = debug_led;
        end
        OFF_SW_EDGE: bus_rdata[NUM_SW-1:0] = sw_edge;
        default:     bus_rdata[NUM_SW-1:0] = irq_en;
      endcase
    end
  end

  // Per-bit debounce: accept sync only after DEBOUNCE_CYCLES consecutive mismatches
  for (genvar i = 0; i < NUM_SW; i++) begin : g_db
    logic [CW-1:0] cnt;
    logic          diff;

    assign diff          = sync[i] ^ stable[i];
    assign stable_nxt[i] = (diff && cnt == CNT_LAST) ? sync[i] : stable[i];

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (diff && cnt != CNT_LAST) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  // A rising edge landing on the same clock as a W1C clear keeps the flag set
  always_comb begin
    clr         = (wr && offset == OFF_SW_EDGE) ? bus_wdata[NUM_SW-1:0] : '0;
    irq_en_nxt  = (wr && offset == OFF_IRQ_EN) ? bus_wdata[NUM_SW-1:0] : irq_en;
    sw_edge_nxt = (sw_edge & ~clr) | (stable_nxt & ~stable);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta      <= '0;
      sync      <= '0;
      stable    <= '0;
      sw_edge   <= '0;
      irq_en    <= '0;
      irq       <= 1'b0;
      leds      <= '0;
      debug_led <= 1'b0;
    end else begin
      meta    <= switches;
      sync    <= meta;
      stable  <= stable_nxt;
      sw_edge <= sw_edge_nxt;
      irq_en  <= irq_en_nxt;
      irq     <= |(sw_edge_nxt & irq_en_nxt);
      if (wr && offset == OFF_LED_OUT) begin
        leds      <= bus_wdata[NUM_LED-1:0];
        debug_led <= bus_wdata[8];
      end
    end
  end

endmodule

// File: tb/tb_mmio_gpio.sv
// Self-checking bench for mmio_gpio: table-driven LED/decode vectors plus
// hand-written debounce, edge/irq, collision and reset sequences.
module tb_mmio_gpio;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int unsigned D    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_rdata;
  logic        bus_hit;
  logic [3:0]  switches;
  logic [3:0]  leds;
  logic        debug_led;
  logic        irq;

  mmio_gpio #(
    .BASE_ADDR(BASE), .NUM_SW(4), .NUM_LED(4), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .bus_hit(bus_hit),
    .switches(switches), .leds(leds), .debug_led(debug_led), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_hit;
    logic [3:0]  exp_leds;
    logic        exp_dbg;
    logic [31:0] exp_rd;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic expect_val(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic compare(input logic [31:0] act);
    sb_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard_empty: got %h with no expected value queued", act);
    end else begin
      e = sb_q.pop_front();
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    expect_val(name, exp);
    compare(act);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_addr = a;
    bus_re   = 1'b1;
    #1;
    d      = bus_rdata;
    bus_re = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    @(posedge clk);
    #1;
    bus_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;

    vecs[0] = '{BASE + 32'h4,  32'h0000_0105, 1'b1, 4'h5, 1'b1, 32'h105};
    vecs[1] = '{BASE + 32'h4,  32'hFFFF_FE00, 1'b1, 4'h0, 1'b0, 32'h000};
    vecs[2] = '{BASE + 32'h4,  32'h0000_000A, 1'b1, 4'hA, 1'b0, 32'h00A};
    vecs[3] = '{BASE + 32'h4,  32'hFFFF_FFFF, 1'b1, 4'hF, 1'b1, 32'h10F};
    vecs[4] = '{BASE + 32'h10, 32'h0000_0000, 1'b0, 4'hF, 1'b1, 32'h10F};
    vecs[5] = '{32'h0000_2004, 32'h0000_0000, 1'b0, 4'hF, 1'b1, 32'h10F};
    vecs[6] = '{BASE + 32'h0,  32'h0000_000F, 1'b1, 4'hF, 1'b1, 32'h10F};
    vecs[7] = '{BASE + 32'h7,  32'h0000_0003, 1'b1, 4'h3, 1'b0, 32'h003};

    rst = 1'b1; bus_addr = '0; bus_wdata = '0; bus_we = 1'b0; bus_re = 1'b0;
    switches = 4'hF;

    // Reset with switches held high
    tick(2);
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_debug_led", 32'(debug_led), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rd(BASE, r); check("rst_sw_in", r, 32'h0);
    rst = 1'b0;
    tick(D + 1);
    rd(BASE, r); check("post_rst_sw_in_early", r, 32'h0);
    tick(1);
    rd(BASE, r);         check("post_rst_sw_in", r, 32'hF);
    rd(BASE + 8, r);     check("post_rst_sw_edge", r, 32'hF);
    check("post_rst_irq_masked", 32'(irq), 32'h0);
    wr(BASE + 8, 32'hF);
    rd(BASE + 8, r);     check("w1c_all", r, 32'h0);
    switches = 4'h0;
    tick(D + 4);
    rd(BASE, r);         check("fall_sw_in", r, 32'h0);
    rd(BASE + 8, r);     check("fall_not_captured", r, 32'h0);

    // LED store and decode vectors
    foreach (vecs[i]) begin
      expect_val($sformatf("vec%0d_hit", i), 32'(vecs[i].exp_hit));
      expect_val($sformatf("vec%0d_leds", i), 32'(vecs[i].exp_leds));
      expect_val($sformatf("vec%0d_debug_led", i), 32'(vecs[i].exp_dbg));
      expect_val($sformatf("vec%0d_readback", i), vecs[i].exp_rd);
      bus_addr  = vecs[i].addr;
      bus_wdata = vecs[i].wdata;
      bus_we    = 1'b1;
      #1;
      compare(32'(bus_hit));
      @(posedge clk);
      #1;
      bus_we = 1'b0;
      compare(32'(leds));
      compare(32'(debug_led));
      rd(BASE + 4, r);
      compare(r);
    end
    rd(BASE, r); check("sw_in_write_ignored", r, 32'h0);

    bus_addr = 32'h0000_2004; bus_re = 1'b1; #1;
    check("miss_read_hit", 32'(bus_hit), 32'h0);
    check("miss_read_data", bus_rdata, 32'h0);
    bus_addr = BASE + 32'h10; #1;
    check("miss_read_data_next_window", bus_rdata, 32'h0);
    bus_re = 1'b0; bus_addr = BASE; #1;
    check("idle_hit", 32'(bus_hit), 32'h0);

    // Same-cycle load and store to LED_OUT sees the old value
    tick(1);
    bus_addr = BASE + 4; bus_wdata = 32'h0000_0105; bus_we = 1'b1; bus_re = 1'b1;
    #1;
    check("raw_same_cycle_read", bus_rdata, 32'h003);
    @(posedge clk); #1;
    bus_we = 1'b0; bus_re = 1'b0;
    rd(BASE + 4, r); check("raw_after_write", r, 32'h105);

    // Clean rise on switch 0
    switches = 4'b0001;
    tick(D + 1);
    rd(BASE, r);     check("db_sw0_early", r, 32'h0);
    tick(1);
    rd(BASE, r);     check("db_sw0", r, 32'h1);
    rd(BASE + 8, r); check("db_sw0_edge", r, 32'h1);
    wr(BASE + 8, 32'h1);
    rd(BASE + 8, r); check("db_sw0_edge_clr", r, 32'h0);

    // Three-cycle glitch on switch 1 is rejected
    switches = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) switches = 4'b0001;
      tick(1);
      rd(BASE, r); check($sformatf("glitch_sw_in_c%0d", i), r, 32'h1);
    end
    rd(BASE + 8, r); check("glitch_no_edge", r, 32'h0);

    // Edge flag and interrupt on switch 1
    wr(BASE + 12, 32'h2);
    rd(BASE + 12, r); check("irq_en_readback", r, 32'h2);
    switches = 4'b0011;
    tick(D + 1);
    check("irq_early", 32'(irq), 32'h0);
    tick(1);
    check("irq_set", 32'(irq), 32'h1);
    rd(BASE + 8, r); check("irq_sw_edge", r, 32'h2);
    rd(BASE, r);     check("irq_sw_in", r, 32'h3);
    wr(BASE + 8, 32'h2);
    check("irq_clr", 32'(irq), 32'h0);
    rd(BASE + 8, r); check("irq_sw_edge_clr", r, 32'h0);

    // W1C of bit 0 on the exact edge stable[0] rises
    switches = 4'b0010;
    tick(D + 4);
    rd(BASE, r);     check("coll_pre_sw_in", r, 32'h2);
    switches = 4'b0011;
    tick(D + 1);
    wr(BASE + 8, 32'h1);
    rd(BASE + 8, r); check("coll_set_wins", r, 32'h1);
    check("coll_irq_masked", 32'(irq), 32'h0);
    wr(BASE + 8, 32'h1);
    rd(BASE + 8, r); check("coll_later_clr", r, 32'h0);

    // Reset mid-operation with switches held high
    wr(BASE + 4, 32'h0000_010F);
    wr(BASE + 12, 32'hF);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_leds", 32'(leds), 32'h0);
    check("mid_rst_debug_led", 32'(debug_led), 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    rd(BASE, r);      check("mid_rst_sw_in", r, 32'h0);
    rd(BASE + 12, r); check("mid_rst_irq_en", r, 32'h0);
    tick(D + 1);
    rd(BASE, r);      check("mid_rst_sw_in_early", r, 32'h0);
    tick(1);
    rd(BASE, r);      check("mid_rst_sw_in_rise", r, 32'h3);
    rd(BASE + 8, r);  check("mid_rst_sw_edge", r, 32'h3);
    check("mid_rst_irq_after", 32'(irq), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
